// File: rtl/fft_out_reorder.sv
// Collects bit-reversed IFFT output frames into a ping-pong buffer and
// replays each completed frame in natural order under valid/ready.
module fft_out_reorder #(
   parameter int STAGE      = 8,
   parameter int REAL_WIDTH = 16,
   parameter int IMGN_WIDTH = 16
) (
   input  logic                  iclk,
   input  logic                  rst_n,
   input  logic                  ien,
   input  logic [STAGE-1:0]      iaddr,
   input  logic [REAL_WIDTH-1:0] iReal,
   input  logic [IMGN_WIDTH-1:0] iImag,
   input  logic                  oready,
   output logic                  ovalid,
   output logic [STAGE-1:0]      oaddr,
   output logic [REAL_WIDTH-1:0] oReal,
   output logic [IMGN_WIDTH-1:0] oImag,
   output logic                  olast,
   output logic                  oovf
);

   localparam int N  = 1 << STAGE;
   localparam int DW = REAL_WIDTH + IMGN_WIDTH;
   localparam logic [STAGE-1:0] LAST_ADDR = {STAGE{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   logic [DW-1:0]         bank0_r [0:N-1];
   logic [DW-1:0]         bank1_r [0:N-1];
   logic [1:0]            full_r, full_s, set_s, clr_s;
   logic                  wsel_r, rsel_r;
   logic [STAGE-1:0]      wcnt_r;
   state_t                state_r, state_s;
   logic                  wr_acc_s, wr_drop_s, wr_done_s;
   logic                  load_s, done_s;
   logic [STAGE-1:0]      rd_addr_s;
   logic [DW-1:0]         rd_data_s;
   logic                  ovalid_r, olast_r, ovf_r;
   logic [STAGE-1:0]      oaddr_r;
   logic [REAL_WIDTH-1:0] oreal_r;
   logic [IMGN_WIDTH-1:0] oimag_r;

   // Write-side acceptance and the set/clear masks for the bank-full flags
   always_comb begin
      wr_acc_s  = ien & ~full_r[wsel_r];
      wr_drop_s = ien &  full_r[wsel_r];
      wr_done_s = wr_acc_s & (wcnt_r == LAST_ADDR);
      set_s     = wr_done_s ? (2'b01 << wsel_r) : 2'b00;
      clr_s     = done_s    ? (2'b01 << rsel_r) : 2'b00;
      full_s    = (full_r | set_s) & ~clr_s;
   end

   // Sample storage; banks carry no reset since their contents are don't-care
   always_ff @(posedge iclk) begin
      if (wr_acc_s) begin
         if (wsel_r) begin
            bank1_r[iaddr] <= {iReal, iImag};
         end else begin
            bank0_r[iaddr] <= {iReal, iImag};
         end
      end
   end

   // Write pointer, bank selects, full flags and the sticky overflow flag
   always_ff @(posedge iclk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_r  <= {STAGE{1'b0}};
         wsel_r  <= 1'b0;
         rsel_r  <= 1'b0;
         full_r  <= 2'b00;
         ovf_r   <= 1'b0;
         state_r <= ST_IDLE;
      end else begin
         full_r  <= full_s;
         state_r <= state_s;
         if (wr_acc_s) begin
            wcnt_r <= wcnt_r + STAGE'(1);
         end
         if (wr_done_s) begin
            wsel_r <= ~wsel_r;
         end
         if (done_s) begin
            rsel_r <= ~rsel_r;
         end
         if (wr_drop_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   // Read FSM: decides when to fetch the next word and when a frame ends
   always_comb begin
      state_s   = state_r;
      load_s    = 1'b0;
      done_s    = 1'b0;
      rd_addr_s = {STAGE{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (full_r[rsel_r]) begin
               load_s  = 1'b1;
               state_s = ST_STREAM;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (ovalid_r & oready) begin
               if (oaddr_r == LAST_ADDR) begin
                  done_s  = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  load_s    = 1'b1;
                  rd_addr_s = oaddr_r + STAGE'(1);
               end
            end else begin
               state_s = ST_STREAM;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Combinational bank read for the word about to be presented
   always_comb begin
      if (rsel_r) begin
         rd_data_s = bank1_r[rd_addr_s];
      end else begin
         rd_data_s = bank0_r[rd_addr_s];
      end
   end

   // Output word registers; held while the sink stalls
   always_ff @(posedge iclk or negedge rst_n) begin
      if (!rst_n) begin
         ovalid_r <= 1'b0;
         olast_r  <= 1'b0;
         oaddr_r  <= {STAGE{1'b0}};
         oreal_r  <= {REAL_WIDTH{1'b0}};
         oimag_r  <= {IMGN_WIDTH{1'b0}};
      end else if (load_s) begin
         ovalid_r <= 1'b1;
         olast_r  <= (rd_addr_s == LAST_ADDR);
         oaddr_r  <= rd_addr_s;
         oreal_r  <= rd_data_s[DW-1:IMGN_WIDTH];
         oimag_r  <= rd_data_s[IMGN_WIDTH-1:0];
      end else if (done_s) begin
         ovalid_r <= 1'b0;
         olast_r  <= 1'b0;
      end
   end

   assign ovalid = ovalid_r;
   assign olast  = olast_r;
   assign oaddr  = oaddr_r;
   assign oReal  = oreal_r;
   assign oImag  = oimag_r;
   assign oovf   = ovf_r;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: a frame-level model predicts the
// ordered output words and the overflow flag; a monitor compares them.
module tb_fft_out_reorder;

   localparam int STAGE = 3;
   localparam int RW    = 16;
   localparam int IW    = 16;
   localparam int N     = 1 << STAGE;
   localparam int WW    = STAGE + RW + IW + 1;

   logic             iclk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ien = 1'b0;
   logic             oready = 1'b0;
   logic [STAGE-1:0] iaddr = '0;
   logic [RW-1:0]    iReal = '0;
   logic [IW-1:0]    iImag = '0;
   logic             ovalid, olast, oovf;
   logic [STAGE-1:0] oaddr;
   logic [RW-1:0]    oReal;
   logic [IW-1:0]    oImag;

   logic [WW-1:0]    exp_q[$];
   logic [RW+IW-1:0] frame_m [N];
   int               wcnt_m = 0;
   int               full_cnt = 0;
   logic             ovf_m = 1'b0;
   int               checks = 0;
   int               failures = 0;
   int               rdy_mode = 0;
   int               cyc = 0;
   bit               gap_chk = 1'b0;
   int               gap = 0;

   fft_out_reorder #(.STAGE(STAGE), .REAL_WIDTH(RW), .IMGN_WIDTH(IW)) dut (
      .iclk(iclk), .rst_n(rst_n), .ien(ien), .iaddr(iaddr), .iReal(iReal),
      .iImag(iImag), .oready(oready), .ovalid(ovalid), .oaddr(oaddr),
      .oReal(oReal), .oImag(oImag), .olast(olast), .oovf(oovf)
   );

   always #5 iclk = ~iclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Sink readiness: 0 always ready, 1 pattern 1,0,0,1, 2 stalled, 3 random
   always @(posedge iclk) begin
      #1;
      cyc++;
      case (rdy_mode)
         0: oready = 1'b1;
         1: oready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         2: oready = 1'b0;
         default: oready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: compare presented words against the scoreboard head
   always @(negedge iclk) begin
      if (rst_n) begin
         chk("oovf", 64'(oovf), 64'(ovf_m));
         if (ovalid) begin
            if (gap_chk) begin
               chk("frame_gap", 64'(gap), 64'd1);
               gap_chk = 1'b0;
            end
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 64'(ovalid), 64'd0);
            end else begin
               chk("word", 64'({oaddr, oReal, oImag, olast}), 64'(exp_q[0]));
               if (oready) begin
                  if (exp_q[0][0]) begin
                     full_cnt--;
                     gap_chk = (exp_q.size() > N);
                     gap = 0;
                  end
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            gap++;
         end
      end
   end

   task automatic idle(input int n);
      ien = 1'b0;
      repeat (n) begin
         @(posedge iclk);
         #1;
      end
   endtask

   // One input sample; the model is updated after the capturing edge
   task automatic send(input logic [STAGE-1:0] a, input logic [RW-1:0] re, input logic [IW-1:0] im);
      bit acc;
      ien   = 1'b1;
      iaddr = a;
      iReal = re;
      iImag = im;
      acc   = (full_cnt < 2);
      @(posedge iclk);
      #1;
      ien = 1'b0;
      if (acc) begin
         frame_m[a] = {re, im};
         wcnt_m++;
         if (wcnt_m == N) begin
            wcnt_m = 0;
            full_cnt++;
            for (int i = 0; i < N; i++) begin
               exp_q.push_back({STAGE'(i), frame_m[i], (i == N - 1)});
            end
         end
      end else begin
         ovf_m = 1'b1;
      end
   endtask

   // kind 0: bit-reversed order with ramp data; kind 1: random permutation/data
   task automatic send_frame(input int kind, input int gap_at, input int gap_len);
      logic [STAGE-1:0] p [N];
      logic [STAGE-1:0] v, t;
      int               j;
      for (int i = 0; i < N; i++) begin
         v = STAGE'(i);
         for (int b = 0; b < STAGE; b++) p[i][b] = v[STAGE-1-b];
      end
      if (kind != 0) begin
         for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = p[i]; p[i] = p[j]; p[j] = t;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (i == gap_at) idle(gap_len);
         if (kind == 0) send(p[i], RW'(10 * int'(p[i])), IW'(-int'(p[i])));
         else           send(p[i], RW'($urandom), IW'($urandom));
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || ovalid) && n < 400) begin
         @(posedge iclk);
         #1;
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #1;
      chk("reset_outputs", 64'({ovalid, olast, oovf, oaddr, oReal, oImag}), 64'd0);
      @(posedge iclk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // Bit-reversed frame, latency of ovalid after the last capture
      rdy_mode = 0;
      send_frame(0, -1, 0);
      chk("latency_k", 64'(ovalid), 64'd0);
      idle(1);
      chk("latency_k1", 64'(ovalid), 64'd1);
      chk("first_addr", 64'(oaddr), 64'd0);
      drain("drain_t1");

      // Two back-to-back frames
      send_frame(1, -1, 0);
      send_frame(1, -1, 0);
      drain("drain_t2");

      // Stalling sink pattern
      rdy_mode = 1;
      send_frame(1, -1, 0);
      drain("drain_t3");

      // Stalled sink, third frame dropped
      rdy_mode = 2;
      idle(2);
      send_frame(1, -1, 0);
      send_frame(1, -1, 0);
      chk("ovf_before", 64'(oovf), 64'd0);
      send(STAGE'(0), RW'(16'h1234), IW'(16'h5678));
      chk("ovf_set", 64'(oovf), 64'd1);
      for (int i = 1; i < N; i++) send(STAGE'(i), RW'($urandom), IW'($urandom));
      idle(5);
      chk("stall_hold", 64'({ovalid, oaddr}), 64'({1'b1, STAGE'(0)}));
      rdy_mode = 0;
      drain("drain_t4");

      // Input gap mid-frame
      send_frame(1, 4, 10);
      drain("drain_t5");

      // Random sink readiness with random input gaps
      rdy_mode = 3;
      repeat (3) begin
         send_frame(1, $urandom_range(0, N - 1), $urandom_range(0, 5));
         drain("drain_rand");
      end

      // Reset in the middle of a readout
      rdy_mode = 0;
      send_frame(1, -1, 0);
      begin
         int n = 0;
         while (!(ovalid && oaddr == STAGE'(3)) && n < 50) begin
            @(posedge iclk);
            #1;
            n++;
         end
         chk("reach_addr3", 64'(oaddr), 64'd3);
      end
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", 64'({ovalid, olast, oovf, oaddr, oReal, oImag}), 64'd0);
      exp_q.delete();
      full_cnt = 0;
      wcnt_m   = 0;
      ovf_m    = 1'b0;
      gap_chk  = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      send_frame(0, -1, 0);
      drain("drain_t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

endmodule
